// File: rtl/bopit_round_sequencer.sv
// Bop-it round controller: requests a move from the generator, times and judges the
// player's answer, and tracks score, lives and difficulty.
module bopit_round_sequencer #(
    parameter int unsigned MOVE_W   = 13,
    parameter int unsigned PLAY_N   = 13,
    parameter int unsigned ELEM_MAX = 4,
    parameter int unsigned LEVEL_UP = 4,
    parameter int unsigned T_START  = 64,
    parameter int unsigned T_STEP   = 8,
    parameter int unsigned T_MIN    = 16,
    parameter int unsigned LIVES    = 3,
    parameter int unsigned STABLE   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              game_start,
    input  logic              tick,
    input  logic              gen_ready,
    input  logic [MOVE_W-1:0] gen_move,
    input  logic [MOVE_W-1:0] player_in,
    output logic              gen_start,
    output logic [3:0]        num_play,
    output logic [2:0]        num_elements,
    output logic [MOVE_W-1:0] target_move,
    output logic              round_active,
    output logic              pass_p,
    output logic              fail_p,
    output logic [7:0]        score,
    output logic [1:0]        lives,
    output logic              game_over
);

    localparam int unsigned WIN_W  = 8;
    localparam int unsigned STAB_W = $clog2(STABLE + 1);
    localparam int unsigned PCNT_W = $clog2(LEVEL_UP + 1);
    // Smallest window that can still shrink by a full step without going below the floor.
    localparam logic [WIN_W:0] WIN_SHRINK_MIN = (WIN_W + 1)'(T_MIN + T_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GEN_LO,
        S_GEN_HI,
        S_RELEASE,
        S_WAIT_IN,
        S_JUDGE,
        S_OVER
    } state_t;

    state_t              state, state_d;
    logic                gen_start_d, pass_d, fail_d, round_active_d, game_over_d;
    logic [2:0]          num_elements_d;
    logic [MOVE_W-1:0]   target_move_d;
    logic [7:0]          score_d;
    logic [1:0]          lives_d;
    logic [WIN_W-1:0]    window, window_d;
    logic [WIN_W-1:0]    timer, timer_d;
    logic [PCNT_W-1:0]   pass_cnt, pass_cnt_d;
    logic [MOVE_W-1:0]   stab_val, stab_val_d, stab_val_nx;
    logic [STAB_W-1:0]   stab_cnt, stab_cnt_d, stab_cnt_nx;
    logic                commit_c, timeout_c;

    assign num_play = 4'(PLAY_N);

    // Track how long player_in has been nonzero and unchanged.
    always_comb begin
        stab_val_nx = player_in;
        stab_cnt_nx = STAB_W'(1);
        if (player_in == '0) begin
            stab_val_nx = '0;
            stab_cnt_nx = '0;
        end else if ((player_in == stab_val) && (stab_cnt != '0)) begin
            stab_val_nx = stab_val;
            stab_cnt_nx = stab_cnt + STAB_W'(1);
        end
    end

    assign commit_c  = (stab_cnt_nx == STAB_W'(STABLE));
    assign timeout_c = tick && (timer <= WIN_W'(1));

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state;
        gen_start_d    = 1'b0;
        pass_d         = 1'b0;
        fail_d         = 1'b0;
        round_active_d = 1'b0;
        game_over_d    = game_over;
        num_elements_d = num_elements;
        target_move_d  = target_move;
        score_d        = score;
        lives_d        = lives;
        window_d       = window;
        timer_d        = timer;
        pass_cnt_d     = pass_cnt;
        stab_val_d     = stab_val;
        stab_cnt_d     = stab_cnt;

        case (state)
            S_IDLE, S_OVER: begin
                if (game_start) begin
                    score_d        = '0;
                    lives_d        = 2'(LIVES);
                    num_elements_d = 3'd1;
                    window_d       = WIN_W'(T_START);
                    pass_cnt_d     = '0;
                    game_over_d    = 1'b0;
                    target_move_d  = '0;
                    gen_start_d    = 1'b1;
                    state_d        = S_REQ;
                end
            end

            S_REQ: state_d = S_GEN_LO;

            // A ready left high from the previous move must drop before a new one counts.
            S_GEN_LO: begin
                if (!gen_ready) state_d = S_GEN_HI;
            end

            S_GEN_HI: begin
                if (gen_ready && (gen_move != '0)) begin
                    target_move_d = gen_move;
                    state_d       = S_RELEASE;
                end
            end

            S_RELEASE: begin
                if (player_in == '0) begin
                    timer_d        = window;
                    stab_val_d     = '0;
                    stab_cnt_d     = '0;
                    round_active_d = 1'b1;
                    state_d        = S_WAIT_IN;
                end
            end

            S_WAIT_IN: begin
                round_active_d = 1'b1;
                stab_val_d     = stab_val_nx;
                stab_cnt_d     = stab_cnt_nx;
                if (tick && (timer != '0)) timer_d = timer - WIN_W'(1);

                // Commit wins over a simultaneous timeout.
                if (commit_c || timeout_c) begin
                    round_active_d = 1'b0;
                    state_d        = S_JUDGE;
                    if (commit_c && (player_in == target_move)) begin
                        pass_d  = 1'b1;
                        score_d = (score == 8'hFF) ? score : score + 8'd1;
                        if (pass_cnt == PCNT_W'(LEVEL_UP - 1)) begin
                            pass_cnt_d     = '0;
                            num_elements_d = (num_elements < 3'(ELEM_MAX)) ?
                                             num_elements + 3'd1 : num_elements;
                            window_d       = ({1'b0, window} >= WIN_SHRINK_MIN) ?
                                             window - WIN_W'(T_STEP) : WIN_W'(T_MIN);
                        end else begin
                            pass_cnt_d = pass_cnt + PCNT_W'(1);
                        end
                    end else begin
                        fail_d     = 1'b1;
                        lives_d    = lives - 2'd1;
                        pass_cnt_d = '0;
                    end
                end
            end

            S_JUDGE: begin
                target_move_d = '0;
                if (lives == '0) begin
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    gen_start_d = 1'b1;
                    state_d     = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            gen_start    <= 1'b0;
            pass_p       <= 1'b0;
            fail_p       <= 1'b0;
            round_active <= 1'b0;
            game_over    <= 1'b0;
            num_elements <= 3'd1;
            target_move  <= '0;
            score        <= '0;
            lives        <= 2'(LIVES);
            window       <= WIN_W'(T_START);
            timer        <= '0;
            pass_cnt     <= '0;
            stab_val     <= '0;
            stab_cnt     <= '0;
        end else begin
            state        <= state_d;
            gen_start    <= gen_start_d;
            pass_p       <= pass_d;
            fail_p       <= fail_d;
            round_active <= round_active_d;
            game_over    <= game_over_d;
            num_elements <= num_elements_d;
            target_move  <= target_move_d;
            score        <= score_d;
            lives        <= lives_d;
            window       <= window_d;
            timer        <= timer_d;
            pass_cnt     <= pass_cnt_d;
            stab_val     <= stab_val_d;
            stab_cnt     <= stab_cnt_d;
        end
    end

endmodule

// File: tb/tb_bopit_round_sequencer.sv
// Scoreboard bench for bopit_round_sequencer: stimulus pushes expected judge results,
// a negedge monitor pops and compares them whenever pass_p or fail_p fires.
`timescale 1ns/1ps
module tb_bopit_round_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, game_start, tick, gen_ready;
    logic [12:0] gen_move, player_in;
    logic        gen_start, round_active, pass_p, fail_p, game_over;
    logic [3:0]  num_play;
    logic [2:0]  num_elements;
    logic [12:0] target_move;
    logic [7:0]  score;
    logic [1:0]  lives;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       pass;
        logic [7:0] score;
        logic [1:0] lives;
        logic [2:0] elem;
    } exp_t;
    exp_t exp_q[$];

    int m_score, m_lives, m_elem, m_pcnt, m_window;

    bopit_round_sequencer dut (
        .clk(clk), .rst_n(rst_n), .game_start(game_start), .tick(tick),
        .gen_ready(gen_ready), .gen_move(gen_move), .player_in(player_in),
        .gen_start(gen_start), .num_play(num_play), .num_elements(num_elements),
        .target_move(target_move), .round_active(round_active), .pass_p(pass_p),
        .fail_p(fail_p), .score(score), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_lives = 3; m_elem = 1; m_pcnt = 0; m_window = 64;
    endtask

    task automatic expect_judge(input logic pass);
        exp_t e;
        if (pass) begin
            if (m_score < 255) m_score++;
            m_pcnt++;
            if (m_pcnt == 4) begin
                m_pcnt = 0;
                if (m_elem < 4) m_elem++;
                m_window = (m_window - 8 < 16) ? 16 : m_window - 8;
            end
        end else begin
            m_lives--;
            m_pcnt = 0;
        end
        e.pass  = pass;
        e.score = 8'(m_score);
        e.lives = 2'(m_lives);
        e.elem  = 3'(m_elem);
        exp_q.push_back(e);
    endtask

    // Monitor: every judge pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (pass_p || fail_p)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_judge: pass_p=%0b fail_p=%0b with empty queue at %0t",
                         pass_p, fail_p, $time);
            end else begin
                e = exp_q.pop_front();
                check("judge_pass", 32'(pass_p), 32'(e.pass));
                check("judge_fail", 32'(fail_p), 32'(!e.pass));
                check("judge_score", 32'(score), 32'(e.score));
                check("judge_lives", 32'(lives), 32'(e.lives));
                check("judge_elements", 32'(num_elements), 32'(e.elem));
            end
        end
    end

    task automatic wait_gen_start();
        logic got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (gen_start) got = 1'b1;
        end
        check("gen_start_seen", 32'(got), 32'd1);
    endtask

    // Called on the negedge where gen_start is visible; plays the generator handshake.
    task automatic serve_after_start(input logic [12:0] mv);
        logic got = 1'b0;
        @(negedge clk);
        check("gen_start_width", 32'(gen_start), 32'd0);
        gen_ready = 1'b0;
        repeat (2) @(negedge clk);
        gen_ready = 1'b1;
        gen_move  = mv;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (round_active) got = 1'b1;
        end
        check("round_active_seen", 32'(got), 32'd1);
        check("target_move", 32'(target_move), 32'(mv));
    endtask

    task automatic start_game(input logic [12:0] mv);
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        check("start_latency", 32'(gen_start), 32'd1);
        check("start_game_over", 32'(game_over), 32'd0);
        model_reset();
        serve_after_start(mv);
    endtask

    task automatic round(input logic [12:0] mv);
        wait_gen_start();
        serve_after_start(mv);
    endtask

    task automatic press(input logic [12:0] val);
        player_in = val;
        repeat (4) @(negedge clk);
        player_in = '0;
    endtask

    task automatic timeout_round(input int w);
        expect_judge(1'b0);
        for (int i = 1; i <= w; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            if (i == w - 1) check("timeout_not_early", 32'(round_active), 32'd1);
            if (i == w)     check("timeout_on_time", 32'(round_active), 32'd0);
            if (i < w) @(negedge clk);
        end
    endtask

    task automatic commit_at_timeout(input logic [12:0] mv, input int w);
        expect_judge(1'b1);
        for (int i = 1; i < w; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
        player_in = mv;
        repeat (3) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        player_in = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gen_start"}, 32'(gen_start), 32'd0);
        check({tag, "_target"}, 32'(target_move), 32'd0);
        check({tag, "_score"}, 32'(score), 32'd0);
        check({tag, "_lives"}, 32'(lives), 32'd3);
        check({tag, "_elements"}, 32'(num_elements), 32'd1);
        check({tag, "_game_over"}, 32'(game_over), 32'd0);
        check({tag, "_round_active"}, 32'(round_active), 32'd0);
        check({tag, "_pulses"}, 32'({pass_p, fail_p}), 32'd0);
        check({tag, "_num_play"}, 32'(num_play), 32'd13);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic saw_start;
        rst_n = 1'b0; game_start = 1'b0; tick = 1'b0;
        gen_ready = 1'b1; gen_move = 13'h1FFF; player_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Game 1: pass, wrong-button fail, timeout fail, commit-vs-timeout, final fail.
        start_game(13'h004);
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        check("ignored_start_gen", 32'(gen_start), 32'd0);
        check("ignored_start_active", 32'(round_active), 32'd1);
        expect_judge(1'b1);
        press(13'h004);

        round(13'h010);
        expect_judge(1'b0);
        press(13'h002);

        round(13'h001);
        timeout_round(64);

        round(13'h100);
        commit_at_timeout(13'h100, 64);

        round(13'h0C0);
        expect_judge(1'b0);
        press(13'h040);
        @(negedge clk);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_target", 32'(target_move), 32'd0);
        check("over_lives", 32'(lives), 32'd0);
        saw_start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (gen_start) saw_start = 1'b1;
        end
        check("over_no_request", 32'(saw_start), 32'd0);

        // Game 2: difficulty ramp, observed through the timeout length.
        start_game(13'h001);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) round(13'(32'd1 << (i % 13)));
            expect_judge(1'b1);
            press(target_move);
        end
        check("elements_after_4", 32'(num_elements), 32'd2);
        round(13'h0A5);
        timeout_round(56);
        for (int i = 0; i < 24; i++) begin
            round(13'(32'd3 << (i % 12)));
            expect_judge(1'b1);
            press(target_move);
        end
        round(13'h1F0);
        timeout_round(16);
        round(13'h00F);
        expect_judge(1'b1);
        press(13'h00F);
        check("final_score", 32'(score), 32'd29);
        check("final_elements", 32'(num_elements), 32'd4);

        // Reset in the middle of a round.
        round(13'h022);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) @(negedge clk);
        check("midreset_hold_gen", 32'(gen_start), 32'd0);
        check("midreset_queue", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start_game(13'h800);
        expect_judge(1'b1);
        press(13'h800);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("after_reset_score", 32'(score), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
